fork_waiter: RTL

FORK_WAITER -- requirements
Module: fork_waiter

---
 rtl/philo_pkg.sv | 23 ++
 rtl/waiter_rr_pick.sv | 56 +++++
 rtl/fork_waiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/philo_pkg.sv
// philo_pkg -- shared definitions for the fork_waiter dining-philosophers arbiter.
//   phil_state_t : per-philosopher state encoding (IDLE/WAIT/EAT)
//   AGE_W        : width of the optional per-philosopher wait-age counter
//   left/right   : ring-neighbor index helpers for a ring of n philosophers
package philo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        EAT  = 2'b10
    } phil_state_t;

    localparam int AGE_W = 4;

    function automatic int unsigned left(input int unsigned i, input int unsigned n);
        return (i + n - 1) % n;
    endfunction

    function automatic int unsigned right(input int unsigned i, input int unsigned n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/waiter_rr_pick.sv
// waiter_rr_pick -- combinational rotating pick over the philosopher ring.
// Scans ptr_i, ptr_i+1, ... once around the ring and picks every waiting
// philosopher whose neighbors are neither eating nor already picked earlier
// in the same scan, and which is not blocked.
//   wait_i     : N-bit, philosopher is waiting
//   eat_i      : N-bit, philosopher is eating (registered state)
//   block_i    : N-bit, philosopher excluded from this scan
//   ptr_i      : scan start index
//   pick_o     : N-bit, philosophers granted this cycle
//   ptr_next_o : (last picked index + 1) mod N, or ptr_i when nothing picked
module waiter_rr_pick
    import philo_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = 3
) (
    input  logic [N-1:0]  wait_i,
    input  logic [N-1:0]  eat_i,
    input  logic [N-1:0]  block_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic [PW-1:0] ptr_next_o
);

    localparam int unsigned NU = N;

    logic [PW-1:0] idx;
    logic [PW-1:0] lft;
    logic [PW-1:0] rgt;
    logic [PW-1:0] last;
    logic          any;

    always_comb begin
        pick_o = '0;
        idx    = '0;
        lft    = '0;
        rgt    = '0;
        last   = '0;
        any    = 1'b0;
        for (int unsigned k = 0; k < NU; k++) begin
            idx = PW'((32'(ptr_i) + k) % NU);
            lft = PW'(left(32'(idx), NU));
            rgt = PW'(right(32'(idx), NU));
            // pick_o only holds indices visited earlier in this scan, so
            // testing it enforces the "picked earlier" neighbor rule.
            if (wait_i[idx] && !block_i[idx] && !eat_i[lft] && !eat_i[rgt] &&
                !pick_o[lft] && !pick_o[rgt]) begin
                pick_o[idx] = 1'b1;
                last        = idx;
                any         = 1'b1;
            end
        end
        ptr_next_o = any ? PW'((32'(last) + 1) % NU) : ptr_i;
    end

endmodule

// File: rtl/fork_waiter.sv
// fork_waiter -- dining-philosophers fork arbiter for a ring of N philosophers.
// Each philosopher moves IDLE -> WAIT (hungry) -> EAT (picked) -> IDLE (done).
// Picks are made from registered state only, so grants never conflict.
//   clk       : clock
//   reset     : asynchronous active-high reset
//   hungry    : N-bit request to eat
//   done      : N-bit release of both forks
//   eat       : N-bit, philosopher i holds forks i and (i+1) mod N (registered)
//   waiting   : N-bit, philosopher i is queued (registered)
//   conflict  : any ring-adjacent pair both eating (combinational, always 0)
//   grant_cnt : saturating count of grants since reset (registered)
// Build option: define FORK_WAITER_AGING_EN to add aging priority, where a
// philosopher waiting AGE_MAX or more cycles blocks both neighbors and is
// picked ahead of the round-robin scan.
module fork_waiter
    import philo_pkg::*;
#(
    parameter int N       = 8,
    parameter int AGE_MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] hungry,
    input  logic [N-1:0] done,
    output logic [N-1:0] eat,
    output logic [N-1:0] waiting,
    output logic         conflict,
    output logic [15:0]  grant_cnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || N > 64) begin : g_bad_n
        $error("fork_waiter: N must be in 2..64");
    end
    if (AGE_MAX < 1 || AGE_MAX > (1 << AGE_W) - 1) begin : g_bad_age
        $error("fork_waiter: AGE_MAX must be in 1..15");
    end

    // {eat_q[i], wait_q[i]} is exactly philosopher i's phil_state_t encoding.
    logic [N-1:0]  eat_q, wait_q, eat_d, wait_d;
    logic [N-1:0]  pick;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [16:0]   n_pick, cnt_sum;
    phil_state_t   cur_st [N];
    phil_state_t   nxt_st [N];

`ifdef FORK_WAITER_AGING_EN
    logic [AGE_W-1:0] age_q [N];
    logic [N-1:0]     starved, block_r, pick_s, pick_r;
    logic [PW-1:0]    ptr_s, ptr_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!wait_d[i])
                    age_q[i] <= '0;
                else if (wait_q[i] && age_q[i] != '1)
                    age_q[i] <= age_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        starved = '0;
        block_r = '0;
        for (int i = 0; i < N; i++)
            starved[i] = wait_q[i] && (age_q[i] >= AGE_W'(AGE_MAX));
        for (int i = 0; i < N; i++)
            block_r[i] = starved[PW'(left(i, N))] | starved[PW'(right(i, N))];
    end

    // Starved philosophers go first; adjacent starved ones are resolved by
    // the scan order of this first pass.
    waiter_rr_pick #(.N(N), .PW(PW)) u_pick_starved (
        .wait_i     (starved),
        .eat_i      (eat_q),
        .block_i    ('0),
        .ptr_i      (ptr_q),
        .pick_o     (pick_s),
        .ptr_next_o (ptr_s)
    );

    waiter_rr_pick #(.N(N), .PW(PW)) u_pick_rr (
        .wait_i     (wait_q & ~starved),
        .eat_i      (eat_q),
        .block_i    (block_r),
        .ptr_i      (ptr_q),
        .pick_o     (pick_r),
        .ptr_next_o (ptr_r)
    );

    assign pick  = pick_s | pick_r;
    assign ptr_d = (|pick_r) ? ptr_r : ptr_s;
`else
    waiter_rr_pick #(.N(N), .PW(PW)) u_pick_rr (
        .wait_i     (wait_q),
        .eat_i      (eat_q),
        .block_i    ('0),
        .ptr_i      (ptr_q),
        .pick_o     (pick),
        .ptr_next_o (ptr_d)
    );
`endif

    always_comb begin
        eat_d  = '0;
        wait_d = '0;
        for (int i = 0; i < N; i++) begin
            cur_st[i] = phil_state_t'({eat_q[i], wait_q[i]});
            nxt_st[i] = cur_st[i];
            case (cur_st[i])
                IDLE:    if (hungry[i]) nxt_st[i] = WAIT;
                WAIT:    if (pick[i])   nxt_st[i] = EAT;
                EAT:     if (done[i])   nxt_st[i] = IDLE;
                default: nxt_st[i] = IDLE;
            endcase
            eat_d[i]  = (nxt_st[i] == EAT);
            wait_d[i] = (nxt_st[i] == WAIT);
        end
    end

    always_comb begin
        n_pick = '0;
        for (int i = 0; i < N; i++) n_pick = n_pick + 17'(pick[i]);
        cnt_sum = {1'b0, cnt_q} + n_pick;
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eat_q  <= '0;
            wait_q <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            eat_q  <= eat_d;
            wait_q <= wait_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < N; i++)
            conflict = conflict | (eat_q[i] & eat_q[PW'(right(i, N))]);
    end

    assign eat       = eat_q;
    assign waiting   = wait_q;
    assign grant_cnt = cnt_q;

endmodule
